// File: rtl/spi_slave_if.sv
// spi_slave_if: oversampled SPI mode-0 slave, 16-bit host frames in, 8-bit read-back byte out.
module spi_slave_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [7:0]  tx_data,
  output logic [15:0] rx_data,
  output logic        wr,
  output logic        frame_err
);
  typedef enum logic [1:0] {WAIT_CS, IDLE, SHIFT, HOLD} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
  logic sck_d, cs_d;
  logic [4:0] bit_cnt;
  logic [15:0] tx_sh, rx_sh;
  logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall, last_bit;
  assign sck_s = sck_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;
  assign last_bit = sck_rise && bit_cnt == 5'd15;
  always_comb begin
    state_n = state;
    case (state)
      WAIT_CS: state_n = cs_s ? IDLE : WAIT_CS;
      IDLE:    state_n = cs_fall ? SHIFT : IDLE;
      SHIFT:   state_n = cs_rise ? IDLE : (last_bit ? HOLD : SHIFT);
      HOLD:    state_n = cs_rise ? IDLE : HOLD;
      default: state_n = WAIT_CS;
    endcase
  end
  // Synchronisers reset low so a CS already held low after reset keeps us in WAIT_CS.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= '0;
      cs_q <= '0;
      mosi_q <= '0;
      sck_d <= 1'b0;
      cs_d <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      cs_q <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sck_d <= sck_s;
      cs_d <= cs_s;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_CS;
      bit_cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      wr <= 1'b0;
      frame_err <= 1'b0;
      spi_miso <= 1'b0;
    end else begin
      state <= state_n;
      wr <= 1'b0;
      frame_err <= 1'b0;
      spi_miso <= (state == SHIFT || state == HOLD) ? tx_sh[15] : 1'b0;
      if (state == IDLE && cs_fall) begin
        tx_sh <= {tx_data, 8'h00};
        bit_cnt <= '0;
        rx_sh <= '0;
      end
      if (state == SHIFT) begin
        if (cs_rise) begin
          frame_err <= 1'b1;
        end else begin
          if (sck_rise) begin
            rx_sh <= {rx_sh[14:0], mosi_s};
            bit_cnt <= bit_cnt + 5'd1;
          end
          if (last_bit) begin
            rx_data <= {rx_sh[14:0], mosi_s};
            wr <= 1'b1;
          end
          if (sck_fall && bit_cnt != 5'd0) tx_sh <= {tx_sh[14:0], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: drives host SPI frames and checks against a frame-level model.
module tb_spi_slave_if;
  logic clk = 1'b0, rst = 1'b1, spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, wr, frame_err;
  logic [7:0] tx_data = 8'h00;
  logic [15:0] rx_data;
  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, err_cnt = 0, cyc = 0, wr_cyc = 0, rise_cyc = 0;
  logic [31:0] miso_cap;
  logic [15:0] exp_rx = 16'h0000;

  spi_slave_if #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .tx_data(tx_data), .rx_data(rx_data), .wr(wr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr) begin
      wr_cnt = wr_cnt + 1;
      wr_cyc = cyc;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host side: n bits MSB first, 4 clk low / 4 clk high, MISO sampled just before each rise.
  task automatic xfer(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[n-1-i];
      wait_clk(4);
      miso_cap = {miso_cap[30:0], spi_miso};
      spi_sck = 1'b1;
      rise_cyc = cyc;
      wait_clk(4);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] bits, input int n, input logic [7:0] txd, input int gap);
    tx_data = txd;
    miso_cap = '0;
    spi_cs_n = 1'b0;
    wait_clk(4);
    xfer(bits, n);
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(gap);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(3);
    vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso got %b want 0", spi_miso); end
    vectors++; if (rx_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rx got %h want 0000", rx_data); end
    vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr got %b want 0", wr); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", frame_err); end
    rst = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_write(input logic [15:0] d, input logic [7:0] txd);
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    frame({16'h0, d}, 16, txd, 8);
    exp_rx = d;
    vectors++; if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL write_wr_count got %0d want 1", wr_cnt - w0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL write_err_count got %0d want 0", err_cnt - e0); end
    vectors++; if (rx_data !== exp_rx) begin miscompares++; $display("FAIL write_rx got %h want %h", rx_data, exp_rx); end
    vectors++; if (miso_cap[15:0] !== {txd, 8'h00}) begin miscompares++; $display("FAIL write_miso got %h want %h", miso_cap[15:0], {txd, 8'h00}); end
    vectors++; if (wr_cyc - rise_cyc !== 3) begin miscompares++; $display("FAIL write_latency got %0d want 3", wr_cyc - rise_cyc); end
  endtask

  task automatic test_readback;
    tx_data = 8'hC3;
    miso_cap = '0;
    spi_cs_n = 1'b0;
    wait_clk(4);
    xfer(32'h5, 4);
    tx_data = 8'h00;
    xfer(32'h0A5, 12);
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
    exp_rx = 16'h50A5;
    vectors++; if (miso_cap[15:0] !== 16'hC300) begin miscompares++; $display("FAIL readback_miso got %h want c300", miso_cap[15:0]); end
    vectors++; if (rx_data !== exp_rx) begin miscompares++; $display("FAIL readback_rx got %h want %h", rx_data, exp_rx); end
  endtask

  task automatic test_short(input int n);
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    frame($urandom, n, 8'($urandom), 8);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL short%0d_err got %0d want 1", n, err_cnt - e0); end
    vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL short%0d_wr got %0d want 0", n, wr_cnt - w0); end
    vectors++; if (rx_data !== exp_rx) begin miscompares++; $display("FAIL short%0d_rx got %h want %h", n, rx_data, exp_rx); end
  endtask

  task automatic test_long;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    frame({12'h0, 16'h8155, 4'hA}, 20, 8'h3C, 8);
    exp_rx = 16'h8155;
    vectors++; if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL long_wr got %0d want 1", wr_cnt - w0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL long_err got %0d want 0", err_cnt - e0); end
    vectors++; if (rx_data !== exp_rx) begin miscompares++; $display("FAIL long_rx got %h want %h", rx_data, exp_rx); end
  endtask

  task automatic test_reset_mid;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    spi_cs_n = 1'b0;
    wait_clk(4);
    xfer(32'h2D, 6);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    xfer(32'h3FF, 10);
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
    exp_rx = 16'h0000;
    vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL rstmid_wr got %0d want 0", wr_cnt - w0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL rstmid_err got %0d want 0", err_cnt - e0); end
    vectors++; if (rx_data !== exp_rx) begin miscompares++; $display("FAIL rstmid_rx got %h want %h", rx_data, exp_rx); end
    test_write(16'h1234, 8'hA5);
  endtask

  task automatic test_back_to_back;
    int w0, e0;
    w0 = wr_cnt; e0 = err_cnt;
    frame(32'hFFFF, 16, 8'h81, 4);
    vectors++; if (rx_data !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_rx1 got %h want ffff", rx_data); end
    vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL b2b_miso_idle got %b want 0", spi_miso); end
    frame(32'h0001, 16, 8'h7E, 8);
    exp_rx = 16'h0001;
    vectors++; if (rx_data !== exp_rx) begin miscompares++; $display("FAIL b2b_rx2 got %h want %h", rx_data, exp_rx); end
    vectors++; if (miso_cap[15:0] !== 16'h7E00) begin miscompares++; $display("FAIL b2b_miso2 got %h want 7e00", miso_cap[15:0]); end
    vectors++; if (wr_cnt - w0 !== 2) begin miscompares++; $display("FAIL b2b_wr got %0d want 2", wr_cnt - w0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL b2b_err got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset;
    test_write(16'h2A5C, 8'h96);
    test_readback;
    test_short(9);
    test_long;
    for (int i = 0; i < 6; i++) test_write(16'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++) test_short(int'($urandom_range(1, 15)));
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
